// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU op sequencer: opcodes, FSM state encodings and
// bit positions within the 7-bit one-hot strobe vector.
package alu_op_sequencer_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_INV = 4'd6;
    localparam logic [3:0] OP_CLR = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam int unsigned NumStrobes = 7;
    localparam int unsigned STB_ADD    = 0;
    localparam int unsigned STB_SUB    = 1;
    localparam int unsigned STB_AND    = 2;
    localparam int unsigned STB_OR     = 3;
    localparam int unsigned STB_XOR    = 4;
    localparam int unsigned STB_INV    = 5;
    localparam int unsigned STB_CLR    = 6;

endpackage

// File: rtl/alu_opcode_decoder.sv
// Combinational opcode decode into the one-hot ALU strobe vector plus
// classification flags (ALU op, load-immediate, legal).
module alu_opcode_decoder
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned OpcodeWidth = 4
) (
    input  logic [OpcodeWidth-1:0] opcode_i,
    output logic [NumStrobes-1:0]  strobe_o,
    output logic                   is_alu_o,
    output logic                   is_ldi_o,
    output logic                   legal_o
);

    always_comb begin
        strobe_o = '0;
        is_ldi_o = 1'b0;
        legal_o  = 1'b1;
        case (opcode_i)
            OpcodeWidth'(OP_NOP): begin
            end
            OpcodeWidth'(OP_ADD): strobe_o[STB_ADD] = 1'b1;
            OpcodeWidth'(OP_SUB): strobe_o[STB_SUB] = 1'b1;
            OpcodeWidth'(OP_AND): strobe_o[STB_AND] = 1'b1;
            OpcodeWidth'(OP_OR):  strobe_o[STB_OR]  = 1'b1;
            OpcodeWidth'(OP_XOR): strobe_o[STB_XOR] = 1'b1;
            OpcodeWidth'(OP_INV): strobe_o[STB_INV] = 1'b1;
            OpcodeWidth'(OP_CLR): strobe_o[STB_CLR] = 1'b1;
            OpcodeWidth'(OP_LDI): is_ldi_o = 1'b1;
            default:              legal_o  = 1'b0;
        endcase
        is_alu_o = |strobe_o;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issuing side of the ALU control interface: accepts one instruction at a time,
// strobes the external ALU for one cycle and captures its result in the accumulator.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned OpcodeWidth = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  logic [OpcodeWidth-1:0] instr_opcode_i,
    input  logic [DataWidth-1:0]   instr_operand_i,
    output logic                   alu_add_o,
    output logic                   alu_sub_o,
    output logic                   alu_and_o,
    output logic                   alu_or_o,
    output logic                   alu_xor_o,
    output logic                   alu_inv_o,
    output logic                   alu_clr_o,
    output logic [DataWidth-1:0]   alu_in1_o,
    output logic [DataWidth-1:0]   alu_in2_o,
    input  logic [DataWidth-1:0]   alu_result_i,
    input  logic                   alu_overflow_i,
    output logic [DataWidth-1:0]   acc_o,
    output logic                   flag_overflow_o,
    output logic                   flag_zero_o,
    output logic                   done_o,
    output logic                   illegal_o
);

    logic [1:0]            state_q, state_d;
    logic [NumStrobes-1:0] strobe_q, strobe_d;
    logic [DataWidth-1:0]  operand_q, operand_d;
    logic [DataWidth-1:0]  acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic                  zero_q, zero_d;
    logic                  is_ldi_q, is_ldi_d;
    logic                  illegal_q, illegal_d;

    logic [NumStrobes-1:0] dec_strobe;
    logic                  dec_is_alu;
    logic                  dec_is_ldi;
    logic                  dec_legal;

    alu_opcode_decoder #(
        .OpcodeWidth (OpcodeWidth)
    ) u_decoder (
        .opcode_i (instr_opcode_i),
        .strobe_o (dec_strobe),
        .is_alu_o (dec_is_alu),
        .is_ldi_o (dec_is_ldi),
        .legal_o  (dec_legal)
    );

    always_comb begin
        state_d   = state_q;
        strobe_d  = '0;
        operand_d = operand_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        is_ldi_d  = is_ldi_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid_i) begin
                    operand_d = instr_operand_i;
                    is_ldi_d  = dec_is_ldi;
                    illegal_d = ~dec_legal;
                    if (dec_is_alu || dec_is_ldi) begin
                        state_d  = StIssue;
                        strobe_d = dec_strobe;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StIssue: begin
                if (is_ldi_q) begin
                    acc_d = operand_q;
                    ovf_d = 1'b0;
                end else begin
                    acc_d = alu_result_i;
                    ovf_d = alu_overflow_i;
                end
                zero_d  = (acc_d == '0);
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            strobe_q  <= '0;
            operand_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            is_ldi_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            strobe_q  <= strobe_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            is_ldi_q  <= is_ldi_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_ready_o   = (state_q == StIdle);
    assign done_o          = (state_q == StDone);
    assign illegal_o       = done_o & illegal_q;

    assign alu_add_o       = strobe_q[STB_ADD];
    assign alu_sub_o       = strobe_q[STB_SUB];
    assign alu_and_o       = strobe_q[STB_AND];
    assign alu_or_o        = strobe_q[STB_OR];
    assign alu_xor_o       = strobe_q[STB_XOR];
    assign alu_inv_o       = strobe_q[STB_INV];
    assign alu_clr_o       = strobe_q[STB_CLR];

    assign alu_in1_o       = acc_q;
    assign alu_in2_o       = operand_q;
    assign acc_o           = acc_q;
    assign flag_overflow_o = ovf_q;
    assign flag_zero_o     = zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: models the external ALU and scoreboards retired instructions.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_opcode;
    logic [7:0] instr_operand;
    logic       alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_inv, alu_clr;
    logic [7:0] alu_in1, alu_in2, alu_result;
    logic       alu_overflow;
    logic [7:0] acc;
    logic       flag_overflow, flag_zero, done, illegal;
    logic [6:0] strobes;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] acc;
        logic       ovf;
        logic       zero;
        logic       ill;
        logic [6:0] stb;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_acc;
    logic       m_ovf;
    logic       m_zero;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .DataWidth   (8),
        .OpcodeWidth (4)
    ) u_dut (
        .clk             (clk),
        .reset           (rst_n),
        .instr_valid_i   (instr_valid),
        .instr_ready_o   (instr_ready),
        .instr_opcode_i  (instr_opcode),
        .instr_operand_i (instr_operand),
        .alu_add_o       (alu_add),
        .alu_sub_o       (alu_sub),
        .alu_and_o       (alu_and),
        .alu_or_o        (alu_or),
        .alu_xor_o       (alu_xor),
        .alu_inv_o       (alu_inv),
        .alu_clr_o       (alu_clr),
        .alu_in1_o       (alu_in1),
        .alu_in2_o       (alu_in2),
        .alu_result_i    (alu_result),
        .alu_overflow_i  (alu_overflow),
        .acc_o           (acc),
        .flag_overflow_o (flag_overflow),
        .flag_zero_o     (flag_zero),
        .done_o          (done),
        .illegal_o       (illegal)
    );

    assign strobes = {alu_clr, alu_inv, alu_xor, alu_or, alu_and, alu_sub, alu_add};

    // External combinational ALU: logic ops work on 4 bits, zero-extended.
    always_comb begin
        alu_result   = 8'h00;
        alu_overflow = 1'b0;
        if (alu_add) {alu_overflow, alu_result} = {1'b0, alu_in1} + {1'b0, alu_in2};
        if (alu_sub) {alu_overflow, alu_result} = {1'b0, alu_in1} - {1'b0, alu_in2};
        if (alu_and) alu_result = {4'h0, alu_in1[3:0] & alu_in2[3:0]};
        if (alu_or)  alu_result = {4'h0, alu_in1[3:0] | alu_in2[3:0]};
        if (alu_xor) alu_result = {4'h0, alu_in1[3:0] ^ alu_in2[3:0]};
        if (alu_inv) alu_result = {4'h0, ~alu_in1[3:0]};
    end

    task automatic push_expected(input logic [3:0] op, input logic [7:0] d);
        exp_t       e;
        logic [8:0] w;
        logic       wr;
        w      = 9'h000;
        wr     = 1'b1;
        e.ill  = 1'b0;
        e.stb  = 7'h00;
        e.lat  = 1;
        case (op)
            4'd1: begin w = {1'b0, m_acc} + {1'b0, d}; e.stb = 7'h01; end
            4'd2: begin w = {1'b0, m_acc} - {1'b0, d}; e.stb = 7'h02; end
            4'd3: begin w = {5'h00, m_acc[3:0] & d[3:0]}; e.stb = 7'h04; end
            4'd4: begin w = {5'h00, m_acc[3:0] | d[3:0]}; e.stb = 7'h08; end
            4'd5: begin w = {5'h00, m_acc[3:0] ^ d[3:0]}; e.stb = 7'h10; end
            4'd6: begin w = {5'h00, ~m_acc[3:0]};         e.stb = 7'h20; end
            4'd7: begin w = 9'h000;                       e.stb = 7'h40; end
            4'd8: w = {1'b0, d};
            4'd0: begin wr = 1'b0; e.lat = 0; end
            default: begin wr = 1'b0; e.lat = 0; e.ill = 1'b1; end
        endcase
        if (wr) begin
            m_acc  = w[7:0];
            m_ovf  = w[8];
            m_zero = (w[7:0] == 8'h00);
        end
        e.acc  = m_acc;
        e.ovf  = m_ovf;
        e.zero = m_zero;
        sb.push_back(e);
    endtask

    // Entered and left #1 after a posedge; returns in the cycle after acceptance.
    task automatic send(input logic [3:0] op, input logic [7:0] d);
        int n = 0;
        instr_valid   = 1'b1;
        instr_opcode  = op;
        instr_operand = d;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            errors++;
            checks++;
            $display("FAIL send_ready: ready=%b required 1", instr_ready);
        end
        push_expected(op, d);
        @(posedge clk); #1;
        instr_valid   = 1'b0;
        instr_opcode  = 4'hA;
        instr_operand = 8'hEE;
    endtask

    task automatic collect(input string name);
        int         n = 0;
        int         stb_cycles = 0;
        logic [6:0] seen = 7'h00;
        exp_t       e;
        while (!done && n < 10) begin
            seen |= strobes;
            if (strobes != 7'h00) stb_cycles++;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done: done=%b required 1", name, done);
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: scoreboard empty, required an entry", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (acc !== e.acc) begin
            errors++;
            $display("FAIL %s_acc: got %h required %h", name, acc, e.acc);
        end
        checks++;
        if (flag_overflow !== e.ovf || flag_zero !== e.zero) begin
            errors++;
            $display("FAIL %s_flags: got ovf=%b zero=%b required ovf=%b zero=%b",
                     name, flag_overflow, flag_zero, e.ovf, e.zero);
        end
        checks++;
        if (illegal !== e.ill) begin
            errors++;
            $display("FAIL %s_illegal: got %b required %b", name, illegal, e.ill);
        end
        checks++;
        if (seen !== e.stb || stb_cycles != int'(e.stb != 7'h00)) begin
            errors++;
            $display("FAIL %s_strobe: got %b for %0d cycles required %b", name, seen,
                     stb_cycles, e.stb);
        end
        checks++;
        if (n != e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, n, e.lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({instr_ready, strobes, acc, flag_overflow, flag_zero, done, illegal, alu_in2}
            !== {1'b1, 7'h00, 8'h00, 4'b0000, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: rdy=%b stb=%b acc=%h ovf=%b z=%b done=%b ill=%b in2=%h",
                     instr_ready, strobes, acc, flag_overflow, flag_zero, done, illegal,
                     alu_in2);
        end
        rst_n = 1'b1;
        m_acc = 8'h00;
        m_ovf = 1'b0;
        m_zero = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        send(4'd8, 8'h7F); collect("ldi_7f");
        send(4'd1, 8'h02); collect("add_02");
        send(4'd1, 8'hFF); collect("add_ff_wrap");
    endtask

    task automatic test_sub_clr();
        send(4'd8, 8'h05); collect("ldi_05");
        send(4'd2, 8'h06); collect("sub_borrow");
        send(4'd7, 8'h55); collect("clr");
    endtask

    task automatic test_logic_illegal();
        send(4'd8, 8'h0C); collect("ldi_0c");
        send(4'd5, 8'h0A); collect("xor_0a");
        send(4'hF, 8'h33); collect("illegal_f");
        send(4'd0, 8'h44); collect("nop");
        send(4'd8, 8'hA6); collect("ldi_a6");
        send(4'd3, 8'hF3); collect("and_f3");
        send(4'd4, 8'h08); collect("or_08");
        send(4'd6, 8'h00); collect("inv");
        send(4'd9, 8'h01); collect("illegal_9");
        send(4'd8, 8'h00); collect("ldi_zero");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(posedge clk); #1;
        send(4'd8, 8'h00); collect("b2b_ldi");
        @(posedge clk); #1;
        instr_valid   = 1'b1;
        instr_opcode  = 4'd1;
        instr_operand = 8'h01;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (instr_ready !== (i % 3 == 0)) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b required %b", i, instr_ready,
                         (i % 3 == 0));
            end
            checks++;
            if (done !== (i % 3 == 2)) begin
                errors++;
                $display("FAIL b2b_done[%0d]: got %b required %b", i, done, (i % 3 == 2));
            end
            if (done && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (acc !== e.acc) begin
                    errors++;
                    $display("FAIL b2b_acc[%0d]: got %h required %h", i, acc, e.acc);
                end
            end
            if (instr_ready) push_expected(4'd1, 8'h01);
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        checks++;
        if (acc !== 8'h03 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_final: acc=%h pending=%0d required acc=03 pending=0", acc,
                     sb.size());
        end
    endtask

    task automatic test_reset_mid_issue();
        int dones = 0;
        @(posedge clk); #1;
        send(4'd8, 8'h33);
        checks++;
        if (alu_in2 !== 8'h33 || instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pre: in2=%h rdy=%b required in2=33 rdy=0", alu_in2,
                     instr_ready);
        end
        sb.delete();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({instr_ready, strobes, acc, done} !== {1'b1, 7'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_state: rdy=%b stb=%b acc=%h done=%b required 1 0 00 0",
                     instr_ready, strobes, acc, done);
        end
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        checks++;
        if (dones != 0 || acc !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_nodone: dones=%0d acc=%h required 0 and 00", dones, acc);
        end
    endtask

    initial begin
        instr_valid   = 1'b0;
        instr_opcode  = 4'h0;
        instr_operand = 8'h00;
        m_acc         = 8'h00;
        m_ovf         = 1'b0;
        m_zero        = 1'b0;
        test_reset();
        test_add();
        test_sub_clr();
        test_logic_illegal();
        test_back_to_back();
        test_reset_mid_issue();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
